// File: rtl/seg7_pkg.sv
// Shared constants, FSM state type and helpers for the 7-segment receive monitor.
// Segment patterns are active-high {g,f,e,d,c,b,a}.
package seg7_pkg;

   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;
   localparam int SEG_W = 7;

   localparam logic [6:0] PAT_0  = 7'h3F;
   localparam logic [6:0] PAT_1  = 7'h06;
   localparam logic [6:0] PAT_2  = 7'h5B;
   localparam logic [6:0] PAT_3  = 7'h4F;
   localparam logic [6:0] PAT_4  = 7'h66;
   localparam logic [6:0] PAT_5  = 7'h6D;
   localparam logic [6:0] PAT_6A = 7'h7D;
   localparam logic [6:0] PAT_6B = 7'h7C;
   localparam logic [6:0] PAT_7A = 7'h07;
   localparam logic [6:0] PAT_7B = 7'h27;
   localparam logic [6:0] PAT_8  = 7'h7F;
   localparam logic [6:0] PAT_9A = 7'h6F;
   localparam logic [6:0] PAT_9B = 7'h67;

   typedef enum logic [1:0] {
      SETTLE  = 2'd0,
      CAPTURE = 2'd1,
      HOLD    = 2'd2
   } state_e;

   // True when exactly one bit of v is set.
   function automatic logic is_onehot(input logic [31:0] v);
      return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational map from an active-high segment pattern to a BCD digit plus legal flag.
// Illegal patterns (including all-dark) report value 0 with legal_o low.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [3:0] value_o,
   output logic       legal_o
);

   always_comb begin
      value_o = 4'd0;
      legal_o = 1'b1;
      case (seg_i)
         PAT_0:          value_o = 4'd0;
         PAT_1:          value_o = 4'd1;
         PAT_2:          value_o = 4'd2;
         PAT_3:          value_o = 4'd3;
         PAT_4:          value_o = 4'd4;
         PAT_5:          value_o = 4'd5;
         PAT_6A, PAT_6B: value_o = 4'd6;
         PAT_7A, PAT_7B: value_o = 4'd7;
         PAT_8:          value_o = 4'd8;
         PAT_9A, PAT_9B: value_o = 4'd9;
         default:        legal_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Receive-side monitor for a multiplexed common-anode 7-segment bus: synchronises the pins,
// waits for each scan slot to settle, decodes it and holds one BCD nibble per position.
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [6:0]              seg_n,
   input  logic [NUM_DIGITS-1:0]   an_n,
   output logic [4*NUM_DIGITS-1:0] digits_out,
   output logic [NUM_DIGITS-1:0]   digit_valid,
   output logic [NUM_DIGITS-1:0]   bad_pattern,
   output logic                    frame_done,
   output logic                    multi_anode_err
);

   localparam int         SW      = NUM_DIGITS + SEG_W;
   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
   localparam logic [7:0] CNT_CAP = 8'(STABLE_CYCLES - 2);

   logic [SW-1:0]           s1_q, s2_q, prev_q;
   logic [7:0]              cnt_q, cnt_d;
   state_e                  state_q, state_d;
   logic                    match;
   logic                    capture_en;

   logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]   valid_q, valid_d;
   logic [NUM_DIGITS-1:0]   bad_q, bad_d;
   logic [NUM_DIGITS-1:0]   seen_q, seen_d;
   logic                    frame_q, frame_d;
   logic                    merr_q, merr_d;

   logic [NUM_DIGITS-1:0]   an_act;
   logic [6:0]              seg_act;
   logic                    an_onehot;
   logic                    an_multi;
   logic [3:0]              dec_value;
   logic                    dec_legal;

   // Two-flop synchroniser plus the previous-sample register used for stability checks.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q   <= '1;
         s2_q   <= '1;
         prev_q <= '1;
         cnt_q  <= '0;
      end else begin
         s1_q   <= {an_n, seg_n};
         s2_q   <= s1_q;
         prev_q <= s2_q;
         cnt_q  <= cnt_d;
      end
   end

   assign match = (s2_q == prev_q);

   always_comb begin
      cnt_d = 8'd0;
      if (match) begin
         cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SETTLE;
      end else begin
         state_q <= state_d;
      end
   end

   // CAPTURE re-checks stability so a slot shorter than STABLE_CYCLES+1 pins cycles is dropped.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SETTLE:  if (match && (cnt_q == CNT_CAP)) state_d = CAPTURE;
         CAPTURE: state_d = match ? HOLD : SETTLE;
         HOLD:    if (!match) state_d = SETTLE;
         default: state_d = SETTLE;
      endcase
   end

   always_comb begin
      capture_en = (state_q == CAPTURE) && match;
   end

   assign an_act    = ~prev_q[SW-1:SEG_W];
   assign seg_act   = ~prev_q[SEG_W-1:0];
   assign an_onehot = is_onehot(32'(an_act));
   assign an_multi  = (|an_act) && !an_onehot;

   seg7_pattern_decode u_decode (
      .seg_i   (seg_act),
      .value_o (dec_value),
      .legal_o (dec_legal)
   );

   // A capture in the frame_done cycle lands after the seen clear, counting toward the next frame.
   always_comb begin
      digits_d = digits_q;
      valid_d  = valid_q;
      bad_d    = bad_q;
      seen_d   = (&seen_q) ? '0 : seen_q;
      frame_d  = &seen_q;
      merr_d   = 1'b0;
      if (capture_en) begin
         if (an_multi) begin
            merr_d = 1'b1;
         end else if (an_onehot) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (an_act[i]) begin
                  if (dec_legal) begin
                     digits_d[4*i +: 4] = dec_value;
                     valid_d[i]         = 1'b1;
                     bad_d[i]           = 1'b0;
                  end else begin
                     valid_d[i]         = 1'b0;
                     bad_d[i]           = 1'b1;
                  end
                  seen_d[i] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q <= '0;
         valid_q  <= '0;
         bad_q    <= '0;
         seen_q   <= '0;
         frame_q  <= 1'b0;
         merr_q   <= 1'b0;
      end else begin
         digits_q <= digits_d;
         valid_q  <= valid_d;
         bad_q    <= bad_d;
         seen_q   <= seen_d;
         frame_q  <= frame_d;
         merr_q   <= merr_d;
      end
   end

   assign digits_out      = digits_q;
   assign digit_valid     = valid_q;
   assign bad_pattern     = bad_q;
   assign frame_done      = frame_q;
   assign multi_anode_err = merr_q;

endmodule
